// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed hex 7-segment driver with a per-frame shadow register.
// Scans NDIGITS digits on i_sample ticks, BLANK_TICKS all-off ticks between digits,
// registered outputs one cycle behind the scan state. Define SEVSEG_LZB_EN for leading-zero blanking.
module seven_seg_scan #(
   parameter int NDIGITS     = 3,
   parameter int BLANK_TICKS = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_sample,
   input  logic                   i_load,
   input  logic [4*NDIGITS-1:0]   i_value,
   input  logic [NDIGITS-1:0]     i_dp,
   output logic [7:0]             o_seg,
   output logic [NDIGITS-1:0]     o_an,
   output logic                   o_frame
);

   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int CW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
   localparam int VW = 4 * NDIGITS;
   localparam int PW = 5 * NDIGITS;

   generate
      if (BLANK_TICKS < 1) begin : g_bad_blank
         $error("seven_seg_scan: BLANK_TICKS must be at least 1");
      end
      if (NDIGITS < 1) begin : g_bad_ndigits
         $error("seven_seg_scan: NDIGITS must be at least 1");
      end
   endgenerate

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   state_t              state;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       next_idx;
   logic [CW-1:0]       cnt;
   logic                started;
   logic [PW-1:0]       pending;   // {dp, value} captured by i_load
   logic [PW-1:0]       frame;     // {dp, value} shown during the current frame
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic [6:0]          cur_seg;
   logic [NDIGITS-1:0]  cur_an;
   logic [NDIGITS-1:0]  lz;        // per-digit segment blanking

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Digit following idx; the very first SHOW after reset always starts at digit 0.
   always_comb begin
      if (!started || idx == IW'(NDIGITS - 1)) begin
         next_idx = '0;
      end else begin
         next_idx = idx + 1'b1;
      end
   end

`ifdef SEVSEG_LZB_EN
   logic zero_run;

   // A digit above 0 is blanked when it and every higher nibble of the frame are zero.
   always_comb begin
      zero_run = 1'b1;
      lz       = '0;
      for (int k = NDIGITS - 1; k > 0; k--) begin
         zero_run = zero_run & (frame[4*k +: 4] == 4'h0);
         lz[k]    = zero_run;
      end
   end
`else
   assign lz = '0;
`endif

   // Anode and segment pattern for the digit currently selected by idx.
   always_comb begin
      cur_nib     = frame[4*int'(idx) +: 4];
      cur_dp      = frame[VW + int'(idx)];
      cur_an      = '1;
      cur_an[idx] = 1'b0;
      cur_seg     = lz[idx] ? 7'h7F : hex_seg(cur_nib);
   end

   // Scan FSM, shadow/frame registers and registered display outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_BLANK;
         idx     <= '0;
         cnt     <= '0;
         started <= 1'b0;
         pending <= '0;
         frame   <= '0;
         o_an    <= '1;
         o_seg   <= 8'hFF;
         o_frame <= 1'b0;
      end else begin
         o_frame <= 1'b0;
         // frame below reads the pre-edge pending, so a coincident load waits a frame
         if (i_load) begin
            pending <= {i_dp, i_value};
         end
         if (i_sample) begin
            case (state)
               ST_SHOW: begin
                  state <= ST_BLANK;
                  cnt   <= '0;
               end
               ST_BLANK: begin
                  if (cnt == CW'(BLANK_TICKS - 1)) begin
                     state   <= ST_SHOW;
                     idx     <= next_idx;
                     started <= 1'b1;
                     if (next_idx == '0) begin
                        frame   <= pending;
                        o_frame <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_BLANK;
            endcase
         end
         if (state == ST_SHOW) begin
            o_an  <= cur_an;
            o_seg <= {~cur_dp, cur_seg};
         end else begin
            o_an  <= '1;
            o_seg <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: table of display values checked through a scoreboard
// of expected lit digits, plus reset, tearing, boundary-load and BLANK_TICKS=3 sequences.
// Expected leading-zero results follow SEVSEG_LZB_EN.
`timescale 1ns/1ps
module tb_seven_seg_scan;

   logic        i_clk   = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_sample = 1'b0;
   logic        i_load  = 1'b0;
   logic [11:0] i_value = '0;
   logic [2:0]  i_dp    = '0;
   logic [7:0]  o_seg;
   logic [2:0]  o_an;
   logic        o_frame;

   logic        sample_b = 1'b1;
   logic        load_b   = 1'b0;
   logic [11:0] value_b  = '0;
   logic [2:0]  dp_b     = '0;
   logic [7:0]  seg_b;
   logic [2:0]  an_b;
   logic        frame_b;

   int          checks = 0;
   int          errors = 0;
   logic        sample_en = 1'b0;
   logic [1:0]  phase = '0;
   logic        mon_en = 1'b0;
   logic [2:0]  prev_an = 3'b111;

   typedef struct packed {
      logic [2:0] an;
      logic [7:0] seg;
   } disp_t;
   disp_t exp_q[$];

   typedef struct {
      logic [11:0] value;
      logic [2:0]  dp;
      logic [7:0]  seg0;
      logic [7:0]  seg1;
      logic [7:0]  seg2;
   } vec_t;
   vec_t vecs[7];

`ifdef SEVSEG_LZB_EN
   localparam logic [7:0] Z1_NODP = 8'hFF;
   localparam logic [7:0] Z2_DP   = 8'h7F;
   localparam logic [7:0] Z2_NODP = 8'hFF;
`else
   localparam logic [7:0] Z1_NODP = 8'hC0;
   localparam logic [7:0] Z2_DP   = 8'h40;
   localparam logic [7:0] Z2_NODP = 8'hC0;
`endif

   seven_seg_scan #(.NDIGITS(3), .BLANK_TICKS(1)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sample(i_sample),
      .i_load  (i_load),
      .i_value (i_value),
      .i_dp    (i_dp),
      .o_seg   (o_seg),
      .o_an    (o_an),
      .o_frame (o_frame)
   );

   seven_seg_scan #(.NDIGITS(3), .BLANK_TICKS(3)) dut_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sample(sample_b),
      .i_load  (load_b),
      .i_value (value_b),
      .i_dp    (dp_b),
      .o_seg   (seg_b),
      .o_an    (an_b),
      .o_frame (frame_b)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic step();
      @(negedge i_clk);
      #1;
   endtask

   task automatic load(input logic [11:0] v, input logic [2:0] d);
      i_value = v;
      i_dp    = d;
      i_load  = 1'b1;
      step();
      i_load  = 1'b0;
   endtask

   task automatic push3(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
      exp_q.push_back('{an: 3'b110, seg: s0});
      exp_q.push_back('{an: 3'b101, seg: s1});
      exp_q.push_back('{an: 3'b011, seg: s2});
   endtask

   task automatic wait_frame(input string name);
      for (int n = 0; n < 200; n++) begin
         step();
         if (o_frame) return;
      end
      timeout(name);
   endtask

   task automatic wait_frame_b(input string name);
      for (int n = 0; n < 200; n++) begin
         step();
         if (frame_b) return;
      end
      timeout(name);
   endtask

   task automatic wait_qsize(input string name, input int sz);
      for (int n = 0; n < 200; n++) begin
         if (exp_q.size() <= sz) return;
         step();
      end
      timeout(name);
      exp_q.delete();
   endtask

   // Scan strobe: one clock wide, every fourth clock while enabled.
   initial begin
      forever begin
         @(negedge i_clk);
         i_sample = sample_en && (phase == 2'd3);
         phase    = phase + 2'd1;
      end
   end

   // Scoreboard: each newly lit digit pops one expectation; each return to blank must be all-off.
   initial begin
      disp_t e;
      forever begin
         @(negedge i_clk);
         if (mon_en) begin
            if (prev_an == 3'b111 && o_an != 3'b111) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("digit_an", o_an, e.an);
                  chk("digit_seg", o_seg, e.seg);
               end
            end else if (prev_an != 3'b111 && o_an == 3'b111) begin
               chk("blank_seg", o_seg, 8'hFF);
            end
         end
         prev_an = o_an;
      end
   end

   initial begin
      vecs[0] = '{12'h123, 3'b000, 8'hB0, 8'hA4, 8'hF9};
      vecs[1] = '{12'h00A, 3'b100, 8'h88, Z1_NODP, Z2_DP};
      vecs[2] = '{12'hF0E, 3'b010, 8'h86, 8'h40, 8'h8E};
      vecs[3] = '{12'h895, 3'b001, 8'h12, 8'h90, 8'h80};
      vecs[4] = '{12'hCDB, 3'b000, 8'h83, 8'hA1, 8'hC6};
      vecs[5] = '{12'h764, 3'b000, 8'h99, 8'h82, 8'hF8};
      vecs[6] = '{12'h000, 3'b000, 8'hC0, Z1_NODP, Z2_NODP};

      // Reset state
      repeat (3) @(negedge i_clk);
      #1;
      chk("rst_an", o_an, 3'b111);
      chk("rst_seg", o_seg, 8'hFF);
      chk("rst_frame", o_frame, 1'b0);
      chk("rst_an_b", an_b, 3'b111);
      i_rst_n = 1'b1;

      // Startup: first lit digit is digit 0 of the first loaded value
      step();
      load(12'h789, 3'b000);
      push3(8'h90, 8'h80, 8'hF8);
      mon_en    = 1'b1;
      sample_en = 1'b1;
      wait_qsize("startup", 0);

      // Table: each value appears from the next frame, digits in order 0,1,2
      for (int i = 0; i < 7; i++) begin
         load(vecs[i].value, vecs[i].dp);
         wait_frame("vec_frame");
         push3(vecs[i].seg0, vecs[i].seg1, vecs[i].seg2);
         wait_qsize("vec_digits", 0);
      end

      // Load coincident with the frame boundary edge
      load(12'hABC, 3'b000);
      wait_frame("bnd_frame_a");
      push3(8'hC6, 8'h83, 8'h88);
      wait_qsize("bnd_digits_a", 0);
      begin
         bit hit = 1'b0;
         for (int n = 0; n < 50 && !hit; n++) begin
            step();
            if (o_an == 3'b111 && i_sample) hit = 1'b1;
         end
         if (!hit) timeout("bnd_edge");
      end
      load(12'hDEF, 3'b000);
      chk("bnd_pulse", o_frame, 1'b1);
      push3(8'hC6, 8'h83, 8'h88);
      wait_qsize("bnd_old_frame", 0);
      wait_frame("bnd_frame_b");
      push3(8'h8E, 8'h86, 8'hA1);
      wait_qsize("bnd_new_frame", 0);

      // No tearing: new load while digit 1 is lit only shows on the next frame
      load(12'h123, 3'b000);
      wait_frame("tear_frame_a");
      push3(8'hB0, 8'hA4, 8'hF9);
      wait_qsize("tear_digit1", 1);
      load(12'h456, 3'b000);
      wait_qsize("tear_digit2", 0);
      wait_frame("tear_frame_b");
      push3(8'h82, 8'h92, 8'h99);
      wait_qsize("tear_new", 0);

      // Asynchronous reset while a digit is lit
      chk("pre_rst_lit", (o_an != 3'b111), 1'b1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst_an", o_an, 3'b111);
      chk("arst_seg", o_seg, 8'hFF);
      chk("arst_frame", o_frame, 1'b0);
      sample_en = 1'b0;
      exp_q.delete();
      step();
      i_rst_n = 1'b1;
      step();
      load(12'h5A1, 3'b000);
      push3(8'hF9, 8'h88, 8'h92);
      sample_en = 1'b1;
      wait_qsize("post_rst", 0);

      // BLANK_TICKS=3 with i_sample held high: 1 lit cycle, 3 dark cycles, 12-cycle frames
      value_b = 12'h321;
      dp_b    = 3'b000;
      load_b  = 1'b1;
      step();
      load_b  = 1'b0;
      wait_frame_b("b_frame1");
      wait_frame_b("b_frame2");
      begin
         logic [7:0] segs_b[3];
         logic [2:0] an_exp;
         logic [7:0] seg_exp;
         int         d;
         segs_b[0] = 8'hF9;
         segs_b[1] = 8'hA4;
         segs_b[2] = 8'hB0;
         for (int j = 1; j <= 24; j++) begin
            step();
            d = ((j - 1) / 4) % 3;
            if ((j - 1) % 4 == 0) begin
               an_exp    = 3'b111;
               an_exp[d] = 1'b0;
               seg_exp   = segs_b[d];
            end else begin
               an_exp  = 3'b111;
               seg_exp = 8'hFF;
            end
            chk("b_an", an_b, an_exp);
            chk("b_seg", seg_b, seg_exp);
            chk("b_frame", frame_b, (j % 12 == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
